// File: rtl/stat_snapshot_reader.sv
// Per-port AXI-stream byte/frame counters with a request/response snapshot reader.
// A read samples one port's counters, including that cycle's beat, and can clear them.
module stat_snapshot_reader #(
    parameter int KEEP_WIDTH        = 8,
    parameter int PORT_COUNT        = 4,
    parameter int BYTE_COUNT_WIDTH  = 32,
    parameter int FRAME_COUNT_WIDTH = 32,
    parameter int KEEP_ENABLE       = (KEEP_WIDTH > 1),
    parameter int SATURATE          = 0,
    parameter int PORT_WIDTH        = ($clog2(PORT_COUNT) > 1) ? $clog2(PORT_COUNT) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PORT_COUNT-1:0]            port_clear,
    input  logic [PORT_COUNT*KEEP_WIDTH-1:0] monitor_axis_tkeep,
    input  logic [PORT_COUNT-1:0]            monitor_axis_tvalid,
    input  logic [PORT_COUNT-1:0]            monitor_axis_tready,
    input  logic [PORT_COUNT-1:0]            monitor_axis_tlast,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [PORT_WIDTH-1:0]            req_port,
    input  logic                             req_clear,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [BYTE_COUNT_WIDTH-1:0]      resp_byte_count,
    output logic [FRAME_COUNT_WIDTH-1:0]     resp_frame_count,
    output logic                             resp_overflow,
    output logic                             resp_error
);

    localparam int BW = BYTE_COUNT_WIDTH;
    localparam int FW = FRAME_COUNT_WIDTH;

    typedef enum logic [1:0] {IDLE, CAPTURE, RESP} state_t;

    state_t                state_q, state_d;
    logic [PORT_WIDTH-1:0] sel_port_q, sel_port_d;
    logic                  sel_clear_q, sel_clear_d;
    logic                  sel_valid;

    logic [BW-1:0]         byte_cnt_q  [PORT_COUNT];
    logic [BW-1:0]         byte_cnt_d  [PORT_COUNT];
    logic [FW-1:0]         frame_cnt_q [PORT_COUNT];
    logic [FW-1:0]         frame_cnt_d [PORT_COUNT];
    logic [PORT_COUNT-1:0] ovf_q, ovf_d;

    logic                  beat       [PORT_COUNT];
    logic                  cap_clr    [PORT_COUNT];
    logic [BW:0]           byte_inc   [PORT_COUNT];
    logic [BW:0]           byte_sum   [PORT_COUNT];
    logic [FW:0]           frame_sum  [PORT_COUNT];
    logic [BW-1:0]         byte_next  [PORT_COUNT];
    logic [FW-1:0]         frame_next [PORT_COUNT];
    logic                  ovf_next   [PORT_COUNT];

    logic [BW-1:0]         snap_byte;
    logic [FW-1:0]         snap_frame;
    logic                  snap_ovf;

    logic [BW-1:0]         resp_byte_q, resp_byte_d;
    logic [FW-1:0]         resp_frame_q, resp_frame_d;
    logic                  resp_ovf_q, resp_ovf_d;
    logic                  resp_err_q, resp_err_d;

    function automatic logic [BW:0] byte_incr(input logic [KEEP_WIDTH-1:0] keep);
        logic [BW:0] cnt;
        cnt = '0;
        if (KEEP_ENABLE != 0) begin
            for (int b = 0; b < KEEP_WIDTH; b++) begin
                cnt = cnt + (BW+1)'(keep[b]);
            end
        end else begin
            cnt = (BW+1)'(1);
        end
        return cnt;
    endfunction

    assign sel_valid = (int'(sel_port_q) < PORT_COUNT);

    // Counter update: a capture clear wins over port_clear, which still keeps this cycle's beat.
    always_comb begin
        ovf_d = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            beat[i]      = monitor_axis_tvalid[i] & monitor_axis_tready[i];
            byte_inc[i]  = beat[i] ? byte_incr(monitor_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH]) : '0;
            byte_sum[i]  = {1'b0, byte_cnt_q[i]} + byte_inc[i];
            frame_sum[i] = {1'b0, frame_cnt_q[i]} + (FW+1)'(beat[i] & monitor_axis_tlast[i]);

            if (byte_sum[i][BW] && (SATURATE != 0)) byte_next[i] = '1;
            else                                    byte_next[i] = byte_sum[i][BW-1:0];
            if (frame_sum[i][FW] && (SATURATE != 0)) frame_next[i] = '1;
            else                                     frame_next[i] = frame_sum[i][FW-1:0];
            ovf_next[i] = ovf_q[i] | byte_sum[i][BW] | frame_sum[i][FW];

            cap_clr[i] = (state_q == CAPTURE) && sel_valid && (int'(sel_port_q) == i)
                         && (sel_clear_q || port_clear[i]);

            if (cap_clr[i]) begin
                byte_cnt_d[i]  = '0;
                frame_cnt_d[i] = '0;
                ovf_d[i]       = 1'b0;
            end else if (port_clear[i]) begin
                byte_cnt_d[i]  = byte_inc[i][BW-1:0];
                frame_cnt_d[i] = FW'(beat[i] & monitor_axis_tlast[i]);
                ovf_d[i]       = 1'b0;
            end else begin
                byte_cnt_d[i]  = byte_next[i];
                frame_cnt_d[i] = frame_next[i];
                ovf_d[i]       = ovf_next[i];
            end
        end
    end

    // Out-of-range ports match no index and therefore snapshot as zero.
    always_comb begin
        snap_byte  = '0;
        snap_frame = '0;
        snap_ovf   = 1'b0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (int'(sel_port_q) == i) begin
                snap_byte  = byte_next[i];
                snap_frame = frame_next[i];
                snap_ovf   = ovf_next[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_port_d   = sel_port_q;
        sel_clear_d  = sel_clear_q;
        resp_byte_d  = resp_byte_q;
        resp_frame_d = resp_frame_q;
        resp_ovf_d   = resp_ovf_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    sel_port_d  = req_port;
                    sel_clear_d = req_clear;
                    state_d     = CAPTURE;
                end
            end
            CAPTURE: begin
                resp_byte_d  = snap_byte;
                resp_frame_d = snap_frame;
                resp_ovf_d   = snap_ovf;
                resp_err_d   = ~sel_valid;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_port_q   <= '0;
            sel_clear_q  <= 1'b0;
            ovf_q        <= '0;
            resp_byte_q  <= '0;
            resp_frame_q <= '0;
            resp_ovf_q   <= 1'b0;
            resp_err_q   <= 1'b0;
            for (int i = 0; i < PORT_COUNT; i++) begin
                byte_cnt_q[i]  <= '0;
                frame_cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            sel_port_q   <= sel_port_d;
            sel_clear_q  <= sel_clear_d;
            ovf_q        <= ovf_d;
            resp_byte_q  <= resp_byte_d;
            resp_frame_q <= resp_frame_d;
            resp_ovf_q   <= resp_ovf_d;
            resp_err_q   <= resp_err_d;
            for (int i = 0; i < PORT_COUNT; i++) begin
                byte_cnt_q[i]  <= byte_cnt_d[i];
                frame_cnt_q[i] <= frame_cnt_d[i];
            end
        end
    end

    assign req_ready        = (state_q == IDLE);
    assign resp_valid       = (state_q == RESP);
    assign resp_byte_count  = resp_byte_q;
    assign resp_frame_count = resp_frame_q;
    assign resp_overflow    = resp_ovf_q;
    assign resp_error       = resp_err_q;

endmodule
